// File: rtl/seg_pkg.sv
// Shared constants, segment patterns and conversion FSM states for the
// six-digit seven-segment scan driver.
package seg_pkg;

  localparam int DIGITS = 6;
  localparam int BIN_W  = 20;
  localparam int BCD_W  = 4 * DIGITS;

  // Largest value that fits on six decimal digits.
  localparam logic [BIN_W-1:0] DATA_MAX = 20'd999_999;

  // Segment patterns are active low, bit 7 = dp, bits 6:0 = g..a.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Map one BCD nibble to its segment pattern; non-decimal codes show blank.
  function automatic logic [7:0] bcd2seg(input logic [3:0] d);
    logic [7:0] pat;
    pat = SEG_BLANK;
    if (d < 4'd10) pat = SEG_DIGIT[d];
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, 20 iterations,
// then a one-cycle DONE before returning to IDLE.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [4:0]       iter_q, iter_d;

  // Add 3 to every nibble that is 5 or more before the next shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state logic: capture on start, shift 20 times, flag DONE for one cycle.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(BIN_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o = (state_q == ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit seven-segment scan driver: converts the input value to BCD once
// per frame, holds it in a display register and multiplexes the digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CNT_MAX = 49_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] data,
  input  logic [5:0]       point,
  input  logic             sign,
  input  logic             seg_en,
  output logic [5:0]       sel,
  output logic [7:0]       seg
);

  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic             started_q;
  logic [5:0]       cap_point_q, cap_point_d;
  logic             cap_sign_q, cap_sign_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic [5:0]       disp_point_q, disp_point_d;
  logic             disp_sign_q, disp_sign_d;
  logic [5:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;

  logic             conv_start, conv_ready, conv_done;
  logic [BIN_W-1:0] data_sat;
  logic [BCD_W-1:0] conv_bcd;
  logic [2:0]       sig_n;
  logic [7:0]       dig_seg [DIGITS];

  // While scanning, a new conversion starts at each frame wrap; while the
  // display is off, a free timer provides the same cadence.
  assign conv_start = !started_q ||
                      (seg_en ? (idx_q == 3'(DIGITS - 1) && cnt_q == CNT_LAST)
                              : (tmr_q == CNT_LAST));
  assign data_sat   = (data > DATA_MAX) ? DATA_MAX : data;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (data_sat),
    .ready_o (conv_ready),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Dwell counter, digit index and disabled-mode start timer.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    tmr_d = tmr_q;
    if (!seg_en) begin
      cnt_d = '0;
      idx_d = '0;
      tmr_d = (tmr_q == CNT_LAST) ? '0 : tmr_q + CNT_W'(1);
    end else begin
      tmr_d = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Point/sign are captured with the data; the display register only ever
  // takes a finished conversion, so scanning never sees partial BCD.
  always_comb begin
    cap_point_d  = cap_point_q;
    cap_sign_d   = cap_sign_q;
    disp_bcd_d   = disp_bcd_q;
    disp_point_d = disp_point_q;
    disp_sign_d  = disp_sign_q;
    if (conv_start && conv_ready) begin
      cap_point_d = point;
      cap_sign_d  = sign;
    end
    if (conv_done) begin
      disp_bcd_d   = conv_bcd;
      disp_point_d = cap_point_q;
      disp_sign_d  = cap_sign_q;
    end
  end

  // Number of significant digits (digit 0 always counts).
  always_comb begin
    sig_n = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (disp_bcd_d[4*i +: 4] != 4'd0) sig_n = 3'(i + 1);
    end
  end

  // Per-digit pattern with leading-zero blanking, minus sign and dp overlay.
  // All base patterns have bit 7 set, so masking bit 7 draws the dp.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [7:0] pat;
      assign pat = (3'(gi) < sig_n) ? bcd2seg(disp_bcd_d[4*gi +: 4]) :
                   (disp_sign_d && 3'(gi) == sig_n) ? SEG_MINUS : SEG_BLANK;
      assign dig_seg[gi] = pat & {~disp_point_d[gi], 7'h7F};
    end
  endgenerate

  // Output pair for the digit being shown next cycle; blank when disabled.
  always_comb begin
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (seg_en) begin
      sel_d = 6'b000001 << idx_d;
      seg_d = dig_seg[idx_d];
    end
  end

  // All registers; reset clears display, counters and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      tmr_q        <= '0;
      idx_q        <= '0;
      started_q    <= 1'b0;
      cap_point_q  <= '0;
      cap_sign_q   <= 1'b0;
      disp_bcd_q   <= '0;
      disp_point_q <= '0;
      disp_sign_q  <= 1'b0;
      sel_q        <= '0;
      seg_q        <= SEG_BLANK;
    end else begin
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      idx_q        <= idx_d;
      started_q    <= 1'b1;
      cap_point_q  <= cap_point_d;
      cap_sign_q   <= cap_sign_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_point_q <= disp_point_d;
      disp_sign_q  <= disp_sign_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a short dwell period.
module tb_seg_scan_driver;

  localparam int CNT_MAX = 9;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [19:0] data   = 20'd0;
  logic [5:0]  point  = 6'd0;
  logic        sign   = 1'b0;
  logic        seg_en = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] exp_q [$];
  logic [13:0] exp_e;
  logic        check_en = 1'b0;
  logic [5:0]  prev_sel = 6'd0;
  int          n;

  always #5 clk = ~clk;

  seg_scan_driver #(.CNT_MAX(CNT_MAX)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .point  (point),
    .sign   (sign),
    .seg_en (seg_en),
    .sel    (sel),
    .seg    (seg)
  );

  // Monitor: each new digit slot pops one expected {sel, seg} pair.
  always @(negedge clk) begin
    if (check_en && sel !== prev_sel && sel !== 6'd0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL slot: got sel=%b seg=%h, expected nothing queued", sel, seg);
      end else begin
        exp_e = exp_q.pop_front();
        if ({sel, seg} !== exp_e) begin
          n_fail++;
          $display("FAIL slot: got sel=%b seg=%h, expected sel=%b seg=%h",
                   sel, seg, exp_e[13:8], exp_e[7:0]);
        end else begin
          $display("[TB] slot sel=%b seg=%h ok", sel, seg);
        end
      end
    end
    prev_sel = sel;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  // pats = {digit5, ..., digit0}
  task automatic push_frame(input logic [47:0] pats, input int first);
    for (int i = first; i < 6; i++) exp_q.push_back({6'(1 << i), pats[8*i +: 8]});
  endtask

  // Wait for a fresh entry into the slot selected by target (bounded).
  task automatic wait_sel(input logic [5:0] target);
    int k;
    k = 0;
    while (sel === target && k < 300) begin @(negedge clk); k++; end
    while (sel !== target && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_sel: got sel=%b, expected sel=%b within 300 cycles", sel, target);
    end
  endtask

  // Let the monitor consume everything queued, then stop checking.
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(posedge clk); k++; end
    if (k >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d slots left, expected 0", exp_q.size());
      exp_q.delete();
    end
    check_en = 1'b0;
    @(negedge clk);
  endtask

  // Check the whole frame that follows the next fresh digit-5 slot.
  task automatic check_frame(input logic [47:0] pats);
    wait_sel(6'b100000);
    @(posedge clk); #1;
    push_frame(pats, 0);
    check_en = 1'b1;
    drain();
  endtask

  initial begin
    data = 20'd123;
    #1 rst = 1'b0;
    #20;
    check("reset_sel", 32'(sel), 32'h00);
    check("reset_seg", 32'(seg), 32'hFF);

    // Release, then reset again in the middle of SHIFT.
    @(negedge clk); rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst_sel", 32'(sel), 32'h00);
    check("midrst_seg", 32'(seg), 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    @(posedge clk); #1;
    check("first_sel", 32'(sel), 32'h01);
    check("first_seg", 32'(seg), 32'hC0);
    n = 1;
    while (dut.u_conv.done_o !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("done_latency", 32'(n), 32'd21);

    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0});       // 123

    data = 20'd123456;
    check_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    data = 20'd42; sign = 1'b1; point = 6'b000010;
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});

    data = 20'd0; sign = 1'b0; point = 6'b000000;
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    data = 20'hFFFFF; sign = 1'b1;
    check_frame({8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

    data = 20'd100; sign = 1'b0;
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0});

    // Change 100 -> 7 during digit 1: the rest of this frame keeps 100.
    wait_sel(6'b000010);
    data = 20'd7;
    @(posedge clk); #1;
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0}, 2);
    check_en = 1'b1;
    drain();
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});

    // Display off, new value converted meanwhile, display back on.
    repeat (2) @(negedge clk);
    seg_en = 1'b0;
    @(posedge clk); #1;
    check("off_sel", 32'(sel), 32'h00);
    check("off_seg", 32'(seg), 32'hFF);
    @(negedge clk); data = 20'd5;
    repeat (60) @(negedge clk);
    seg_en = 1'b1;
    @(posedge clk); #1;
    check("on_sel", 32'(sel), 32'h01);
    check("on_seg", 32'(seg), 32'h92);
    n = 0;
    while (sel === 6'd1 && n < 40) begin n++; @(posedge clk); #1; end
    check("on_dwell", 32'(n), 32'(CNT_MAX));
    check("on_next_sel", 32'(sel), 32'h02);
    check("on_next_seg", 32'(seg), 32'hFF);
    @(negedge clk);
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
